mul_sequencer: RTL

Multi-cycle multiply controller for the execute stage. It takes over R-type MUL instructions (ALUOp 2'b10, funct 6'b000010) from the single-cycle ALU path and runs a shift-add multiplier for WIDTH cycles. While it runs, it holds a stall to the upstream pipeline registers. It then presents the low WIDTH bits of the product for one cycle so the EX/MEM register can capture it.

---
 rtl/mul_sequencer_if.sv | 32 +++
 rtl/mul_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mul_sequencer_if.sv
// ============================================================================
// mul_sequencer_if : EX-stage request/response bundle for the multiply sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       ALUOp;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;

  modport master (
    output start, ALUOp, funct, rs, rt, flush,
    input  stall, busy, done, product
  );

  modport slave (
    input  start, ALUOp, funct, rs, rt, flush,
    output stall, busy, done, product
  );
endinterface

`default_nettype wire

// File: rtl/mul_sequencer.sv
// ============================================================================
// mul_sequencer : multi-cycle shift-add MUL controller with pipeline stall
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_sequencer_if.slave bus
);

  localparam int COUNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   product_q;
  logic [WIDTH-1:0]   addend;
  logic [COUNT_W-1:0] count;
  logic               is_mul;
  logic               accept;
  logic               last_step;
  logic               stall_c;
  logic               busy_c;
  logic               done_c;

  assign is_mul    = bus.start && (bus.ALUOp == 2'b10) && (bus.funct == 6'b000010);
  assign accept    = is_mul && !bus.flush;
  assign last_step = (count == COUNT_W'(WIDTH - 1));
  assign addend    = mplier[0] ? mcand : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // stall covers the acceptance cycle combinationally so ID/EX holds the MUL
  always_comb begin
    stall_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE:    stall_c = accept;
      RUN: begin
        stall_c = 1'b1;
        busy_c  = 1'b1;
      end
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.stall   = stall_c;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.product = product_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= bus.rs;
            mplier <= bus.rt;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          if (!bus.flush) begin
            acc    <= acc + addend;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + COUNT_W'(1);
            if (last_step) begin
              product_q <= acc + addend;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
